// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu -- MEM pipeline stage with a handshaked data-SRAM load/store unit.
//
// Sits between EX and WB. It holds one instruction and waits for that
// instruction's data_ok when EX issued a data-SRAM request for it. Sub-word
// loads and LWL/LWR merges are aligned here. A response that arrives while WB
// is stalled is kept in a one-entry buffer. Responses owed to loads that were
// flushed while in MEM are counted and discarded as they return. The stage
// also publishes forward/block information to ID.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   ws_allowin          WB can accept
//   ms_allowin          MEM can accept from EX
//   es_to_ms_valid/bus  EX output. From the LSB upward the bus holds pc,
//                       exe_result, rt_old, dest, gr_we, wait_data,
//                       res_from_mem and ld_type[2:0]. The top two bits are
//                       reserved and ignored.
//   ms_to_ws_valid/bus  MEM output {gr_we, dest, final_result, pc}
//   ms_flush            exception/eret flush; kills the MEM content
//   data_sram_data_ok   response strobe, one per request, in request order
//   data_sram_rdata     response data, valid with data_ok
//   ms_fwd_blk_bus      {1'b0, fwd_valid[3:0], blk, dest, fwd_data[31:0]}
//   ms_stall_cnt        cycles spent waiting on the data SRAM
//
// Optional build macro MS_PERF_STALL_CNT_EN: when it is defined, ms_stall_cnt
// is a free-running 32-bit counter that is cleared by reset only. When it is
// undefined, ms_stall_cnt is tied to zero.

module mem_stage_lsu #(
    parameter int DEST_WD     = 5,
    parameter int DROP_CNT_WD = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ws_allowin,
    output logic                     ms_allowin,
    input  logic                     es_to_ms_valid,
    input  logic [104+DEST_WD-1:0]   es_to_ms_bus,
    output logic                     ms_to_ws_valid,
    output logic [65+DEST_WD-1:0]    ms_to_ws_bus,
    input  logic                     ms_flush,
    input  logic                     data_sram_data_ok,
    input  logic [31:0]              data_sram_rdata,
    output logic [38+DEST_WD-1:0]    ms_fwd_blk_bus,
    output logic [31:0]              ms_stall_cnt
);

    localparam int ES_USED = 102 + DEST_WD;

    localparam logic [2:0] LD_LB  = 3'b001;
    localparam logic [2:0] LD_LBU = 3'b010;
    localparam logic [2:0] LD_LH  = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b100;
    localparam logic [2:0] LD_LWL = 3'b101;
    localparam logic [2:0] LD_LWR = 3'b110;

    localparam logic [DROP_CNT_WD-1:0] DROP_MAX = '1;
    localparam logic [DROP_CNT_WD-1:0] DROP_ONE = {{(DROP_CNT_WD-1){1'b0}}, 1'b1};

    logic [ES_USED-1:0]      es_bus_r;
    logic                    ms_valid;
    logic                    buf_vld;
    logic [31:0]             buf_data;
    logic [DROP_CNT_WD-1:0]  drop_cnt;

    logic [2:0]              ld_type;
    logic                    res_from_mem;
    logic                    wait_data;
    logic                    gr_we;
    logic [DEST_WD-1:0]      dest;
    logic [31:0]             rt_old;
    logic [31:0]             exe_result;
    logic [31:0]             pc;

    logic                    es_wait_data;
    logic                    unused_es_hi;

    logic                    resp_live;
    logic                    resp_drop;
    logic                    resp_capture;
    logic                    ms_ready_go;
    logic                    ms_leave;
    logic                    drop_hold;
    logic                    drop_inc;
    logic [31:0]             resp_data;
    logic [1:0]              addr_lo;
    logic [7:0]              load_byte;
    logic [15:0]             load_half;
    logic [31:0]             load_value;
    logic [31:0]             final_result;
    logic                    fwd_v;
    logic                    blk;

    assign pc           = es_bus_r[31:0];
    assign exe_result   = es_bus_r[63:32];
    assign rt_old       = es_bus_r[95:64];
    assign dest         = es_bus_r[96 +: DEST_WD];
    assign gr_we        = es_bus_r[96+DEST_WD];
    assign wait_data    = es_bus_r[97+DEST_WD];
    assign res_from_mem = es_bus_r[98+DEST_WD];
    assign ld_type      = es_bus_r[99+DEST_WD +: 3];

    assign es_wait_data = es_to_ms_bus[97+DEST_WD];
    assign unused_es_hi = ^es_to_ms_bus[104+DEST_WD-1:ES_USED];

    // A response is live only when no response of a flushed load is still
    // outstanding ahead of it. Responses return in order, so all pending
    // drops are consumed first.
    assign resp_live    = data_sram_data_ok && (drop_cnt == '0);
    assign resp_drop    = data_sram_data_ok && (drop_cnt != '0);
    assign resp_capture = resp_live && ms_valid && wait_data && !buf_vld;

    assign ms_ready_go    = !wait_data || buf_vld || resp_live;
    assign ms_to_ws_valid = ms_valid && ms_ready_go;
    assign ms_leave       = ms_to_ws_valid && ws_allowin;

    // When the drop counter is full, a new requesting instruction could owe
    // a response that the counter can no longer track, so it is held in EX.
    assign drop_hold  = (drop_cnt == DROP_MAX) && es_to_ms_valid && es_wait_data;
    assign ms_allowin = (!ms_valid || (ms_ready_go && ws_allowin)) && !drop_hold;

    // A flushed load whose response has not yet returned leaves one response
    // in flight. That response must be discarded later.
    assign drop_inc = ms_flush && ms_valid && wait_data && !buf_vld && !resp_live
                      && (drop_cnt != DROP_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid <= 1'b0;
            buf_vld  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            // Leaving is handled on its own so that the stage empties even
            // while a held-off entry keeps ms_allowin low.
            if (ms_flush) begin
                ms_valid <= 1'b0;
            end else if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;
            end else if (ms_leave) begin
                ms_valid <= 1'b0;
            end

            if (ms_flush || ms_leave) begin
                buf_vld <= 1'b0;
            end else if (resp_capture) begin
                buf_vld <= 1'b1;
            end

            case ({drop_inc, resp_drop})
                2'b10:   drop_cnt <= drop_cnt + DROP_ONE;
                2'b01:   drop_cnt <= drop_cnt - DROP_ONE;
                default: drop_cnt <= drop_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (resp_capture) begin
            buf_data <= data_sram_rdata;
        end
        if (es_to_ms_valid && ms_allowin && !ms_flush) begin
            es_bus_r <= es_to_ms_bus[ES_USED-1:0];
        end
    end

    assign resp_data = buf_vld ? buf_data : data_sram_rdata;
    assign addr_lo   = exe_result[1:0];
    assign load_half = addr_lo[1] ? resp_data[31:16] : resp_data[15:0];

    always_comb begin
        load_byte = resp_data[7:0];
        case (addr_lo)
            2'd1:    load_byte = resp_data[15:8];
            2'd2:    load_byte = resp_data[23:16];
            2'd3:    load_byte = resp_data[31:24];
            default: load_byte = resp_data[7:0];
        endcase
    end

    always_comb begin
        load_value = resp_data;
        case (ld_type)
            LD_LB:   load_value = {{24{load_byte[7]}}, load_byte};
            LD_LBU:  load_value = {24'h000000, load_byte};
            LD_LH:   load_value = {{16{load_half[15]}}, load_half};
            LD_LHU:  load_value = {16'h0000, load_half};
            LD_LWL: begin
                case (addr_lo)
                    2'd0:    load_value = {resp_data[7:0],  rt_old[23:0]};
                    2'd1:    load_value = {resp_data[15:0], rt_old[15:0]};
                    2'd2:    load_value = {resp_data[23:0], rt_old[7:0]};
                    default: load_value = resp_data;
                endcase
            end
            LD_LWR: begin
                case (addr_lo)
                    2'd0:    load_value = resp_data;
                    2'd1:    load_value = {rt_old[31:24], resp_data[31:8]};
                    2'd2:    load_value = {rt_old[31:16], resp_data[31:16]};
                    default: load_value = {rt_old[31:8],  resp_data[31:24]};
                endcase
            end
            default: load_value = resp_data;
        endcase
    end

    assign final_result = res_from_mem ? load_value : exe_result;
    assign ms_to_ws_bus = {gr_we, dest, final_result, pc};

    assign fwd_v = ms_valid && gr_we && ms_ready_go;
    assign blk   = ms_valid && gr_we && res_from_mem && !ms_ready_go;
    assign ms_fwd_blk_bus = {1'b0, {4{fwd_v}}, blk, dest, final_result};

`ifdef MS_PERF_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else if (ms_valid && wait_data && !ms_ready_go) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign ms_stall_cnt = stall_cnt_q;
`else
    assign ms_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    localparam int DEST_WD  = 5;
    localparam int DROP_MAX = 3;

    logic                   clk;
    logic                   reset;
    logic                   ws_allowin;
    logic                   ms_allowin;
    logic                   es_to_ms_valid;
    logic [104+DEST_WD-1:0] es_to_ms_bus;
    logic                   ms_to_ws_valid;
    logic [65+DEST_WD-1:0]  ms_to_ws_bus;
    logic                   ms_flush;
    logic                   data_sram_data_ok;
    logic [31:0]            data_sram_rdata;
    logic [38+DEST_WD-1:0]  ms_fwd_blk_bus;
    logic [31:0]            ms_stall_cnt;

    mem_stage_lsu #(.DEST_WD(DEST_WD), .DROP_CNT_WD(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_flush          (ms_flush),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_fwd_blk_bus    (ms_fwd_blk_bus),
        .ms_stall_cnt      (ms_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // stimulus for the next cycle
    logic        s_reset, s_esv, s_rfm, s_wd, s_gwe, s_ws, s_flush, s_dok;
    logic [2:0]  s_ld;
    logic [4:0]  s_dest;
    logic [31:0] s_rt, s_exe, s_pc, s_rdata;

    // reference model: one MEM slot plus the in-order list of owed responses
    // (1 = owed to a killed load, 0 = owed to the slot)
    bit          kq[$];
    bit          m_known = 0;
    logic        m_valid, m_have;
    logic [2:0]  m_ld;
    logic        m_rfm, m_wd, m_gwe;
    logic [4:0]  m_dest;
    logic [31:0] m_rt, m_exe, m_pc, m_data;
    logic [31:0] m_stall;

    // observations of the last step, for directed checks
    logic        obs_valid, obs_allowin, obs_blk;
    logic [3:0]  obs_fwdv;
    logic [31:0] obs_result;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] load_value(input logic [2:0] ld, input logic [1:0] a,
                                               input logic [31:0] r, input logic [31:0] t);
        int ai;
        logic [31:0] v;
        ai = int'(a);
        case (ld)
            3'd1: begin v = (r >> (8*ai)) & 32'hFF;   if (v[7])  v = v | 32'hFFFF_FF00; end
            3'd2: v = (r >> (8*ai)) & 32'hFF;
            3'd3: begin v = (r >> (a[1] ? 16 : 0)) & 32'hFFFF; if (v[15]) v = v | 32'hFFFF_0000; end
            3'd4: v = (r >> (a[1] ? 16 : 0)) & 32'hFFFF;
            3'd5: v = (ai == 3) ? r : ((r << (8*(3-ai))) | (t & ((32'h1 << (8*(3-ai))) - 32'h1)));
            3'd6: v = (ai == 0) ? r : ((r >> (8*ai)) | (t & ~(32'hFFFF_FFFF >> (8*ai))));
            default: v = r;
        endcase
        return v;
    endfunction

    task automatic idle();
        s_reset = 0; s_esv = 0; s_flush = 0; s_dok = 0; s_ws = 1;
        s_ld = 3'd0; s_rfm = 0; s_wd = 0; s_gwe = 0; s_dest = 5'd0;
        s_rt = $urandom; s_exe = $urandom; s_pc = $urandom; s_rdata = $urandom;
    endtask

    task automatic present_load(input logic [2:0] ld, input logic [31:0] exe, input logic [31:0] rt);
        s_esv = 1; s_ld = ld; s_rfm = 1; s_wd = 1; s_gwe = 1;
        s_dest = 5'd7; s_exe = exe; s_rt = rt; s_pc = 32'hBFC0_0000 + exe;
    endtask

    task automatic step();
        int killed;
        bit live, ready, ovalid, allow, b;
        logic [31:0] fr;
        @(negedge clk);
        reset             = s_reset;
        es_to_ms_valid    = s_esv;
        es_to_ms_bus      = {2'b00, s_ld, s_rfm, s_wd, s_gwe, s_dest, s_rt, s_exe, s_pc};
        ws_allowin        = s_ws;
        ms_flush          = s_flush;
        data_sram_data_ok = s_dok;
        data_sram_rdata   = s_rdata;
        #1;
        killed = 0;
        foreach (kq[i]) if (kq[i]) killed++;
        live   = s_dok && (kq.size() > 0) && (kq[0] == 1'b0);
        ready  = !m_wd || m_have || live;
        ovalid = m_valid && ready;
        allow  = (!m_valid || (ready && s_ws)) && !(killed == DROP_MAX && s_esv && s_wd);
        fr     = m_rfm ? load_value(m_ld, m_exe[1:0], m_have ? m_data : s_rdata, m_rt) : m_exe;

        obs_valid   = ms_to_ws_valid;
        obs_allowin = ms_allowin;
        obs_result  = ms_to_ws_bus[63:32];
        obs_blk     = ms_fwd_blk_bus[37];
        obs_fwdv    = ms_fwd_blk_bus[41:38];

        if (m_known) begin
            check("ms_allowin", ms_allowin, allow);
            check("ms_to_ws_valid", ms_to_ws_valid, ovalid);
            check("fwd_valid", ms_fwd_blk_bus[41:38], {4{m_valid && m_gwe && ready}});
            check("blk", ms_fwd_blk_bus[37], m_valid && m_gwe && m_rfm && !ready);
            if (ovalid) begin
                check("ms_to_ws_bus", ms_to_ws_bus, {m_gwe, m_dest, fr, m_pc});
                check("fwd_data", ms_fwd_blk_bus[31:0], fr);
                check("fwd_dest", ms_fwd_blk_bus[36:32], m_dest);
            end
`ifdef MS_PERF_STALL_CNT_EN
            check("ms_stall_cnt", ms_stall_cnt, m_stall);
`else
            check("ms_stall_cnt", ms_stall_cnt, 32'd0);
`endif
        end

        if (s_reset) begin
            kq.delete();
            m_valid = 0; m_have = 0; m_stall = 0; m_known = 1;
            m_wd = 0; m_rfm = 0; m_gwe = 0;
        end else if (m_known) begin
            if (m_valid && m_wd && !ready) m_stall = m_stall + 32'd1;
            if (s_dok && kq.size() > 0) begin
                b = kq.pop_front();
                if (!b) begin m_have = 1; m_data = s_rdata; end
            end
            if (s_flush) begin
                foreach (kq[i]) if (!kq[i]) kq[i] = 1'b1;
                m_valid = 0; m_have = 0;
            end else if (ovalid && s_ws) begin
                m_valid = 0; m_have = 0;
            end
            if (s_esv && allow && !s_flush) begin
                m_valid = 1; m_have = 0;
                m_ld = s_ld; m_rfm = s_rfm; m_wd = s_wd; m_gwe = s_gwe; m_dest = s_dest;
                m_rt = s_rt; m_exe = s_exe; m_pc = s_pc;
                if (s_wd) kq.push_back(1'b0);
            end
        end
    endtask

    task automatic do_reset();
        idle(); s_reset = 1; step(); step(); idle();
    endtask

    initial begin
        m_valid = 0; m_have = 0; m_stall = 0;
        m_wd = 0; m_rfm = 0; m_gwe = 0;
        m_ld = 0; m_dest = 0; m_rt = 0; m_exe = 0; m_pc = 0; m_data = 0;
        idle();
        do_reset();

        // reset state
        step();
        check("reset_allowin", obs_allowin, 1'b1);
        check("reset_valid", obs_valid, 1'b0);
        check("reset_fwdv", obs_fwdv, 4'h0);

        // LB a=3, response two cycles after entry
        do_reset();
        present_load(3'd1, 32'h0000_1003, 32'h0);
        step();
        idle(); step();
        check("lb_blk_1", obs_blk, 1'b1);
        step();
        check("lb_blk_2", obs_blk, 1'b1);
        s_dok = 1; s_rdata = 32'h80FF_1234; step();
        check("lb_valid", obs_valid, 1'b1);
        check("lb_result", obs_result, 32'hFFFF_FF80);
        check("lb_fwdv", obs_fwdv, 4'hF);
        idle(); step();
        check("lb_left", obs_valid, 1'b0);
`ifdef MS_PERF_STALL_CNT_EN
        check("lb_stall_cnt", ms_stall_cnt, 32'd2);
`endif

        // LWR a=1 then LWL a=2, back to back
        do_reset();
        present_load(3'd6, 32'h0000_2001, 32'hAABB_CCDD);
        step();
        present_load(3'd5, 32'h0000_2002, 32'hAABB_CCDD);
        s_dok = 1; s_rdata = 32'h1122_3344; step();
        check("lwr_result", obs_result, 32'hAA11_2233);
        idle(); s_dok = 1; s_rdata = 32'h1122_3344; step();
        check("lwl_valid", obs_valid, 1'b1);
        check("lwl_result", obs_result, 32'h2233_44DD);
        idle(); step();

        // response arrives while WB is stalled
        do_reset();
        present_load(3'd0, 32'h0000_0100, 32'h0);
        step();
        idle(); s_ws = 0; s_dok = 1; s_rdata = 32'h5555_AAAA; step();
        s_dok = 0; s_rdata = 32'h0; step();
        check("buf_vld_set", dut.buf_vld, 1'b1);
        check("buf_held", obs_result, 32'h5555_AAAA);
        step();
        s_ws = 1; step();
        check("buf_out_valid", obs_valid, 1'b1);
        check("buf_out_result", obs_result, 32'h5555_AAAA);
        idle(); step();
        check("buf_vld_clr", dut.buf_vld, 1'b0);

        // flushed load's response is dropped
        do_reset();
        present_load(3'd0, 32'h0000_0100, 32'h0);
        step();
        idle(); s_flush = 1; step();
        idle(); present_load(3'd0, 32'h0000_0200, 32'h0); step();
        idle(); s_dok = 1; s_rdata = 32'hDEAD_BEEF; step();
        check("drop_cnt_1", dut.drop_cnt, 2'd1);
        check("drop_no_valid", obs_valid, 1'b0);
        idle(); s_dok = 1; s_rdata = 32'h1234_5678; step();
        check("drop_cnt_0", dut.drop_cnt, 2'd0);
        check("after_drop_valid", obs_valid, 1'b1);
        check("after_drop_result", obs_result, 32'h1234_5678);
        idle(); step();

        // drop counter full holds off a requesting entry
        do_reset();
        for (int k = 0; k < 3; k++) begin
            idle(); present_load(3'd0, 32'h0000_0300, 32'h0); step();
            idle(); s_flush = 1; step();
        end
        idle(); present_load(3'd0, 32'h0000_0400, 32'h0); step();
        check("drop_cnt_max", dut.drop_cnt, 2'd3);
        check("full_hold", obs_allowin, 1'b0);
        s_dok = 1; step();
        s_dok = 0; step();
        check("full_release", obs_allowin, 1'b1);
        idle();
        for (int k = 0; k < 10 && kq.size() > 0; k++) begin
            idle(); s_dok = 1; step();
        end
        check("drain_done", kq.size(), 0);
        idle(); step();

        // reset while a buffered load waits
        do_reset();
        present_load(3'd0, 32'h0000_0500, 32'h0);
        step();
        idle(); s_ws = 0; step();
        s_dok = 1; s_rdata = 32'hCAFE_F00D; step();
        s_dok = 0; step();
        check("pre_reset_buf", dut.buf_vld, 1'b1);
        s_reset = 1; step();
        idle(); step();
        check("rst_valid", obs_valid, 1'b0);
        check("rst_buf_vld", dut.buf_vld, 1'b0);
        check("rst_drop_cnt", dut.drop_cnt, 2'd0);
        check("rst_stall_cnt", ms_stall_cnt, 32'd0);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            s_reset = ($urandom % 500) == 0;
            s_esv   = ($urandom % 100) < 60;
            s_ld    = 3'($urandom_range(0, 7));
            s_rfm   = 1'($urandom % 2);
            s_wd    = s_rfm ? 1'b1 : 1'($urandom % 2);
            s_gwe   = 1'($urandom % 2);
            s_dest  = 5'($urandom);
            s_rt    = $urandom;
            s_exe   = $urandom;
            s_pc    = $urandom;
            s_ws    = ($urandom % 100) < 70;
            s_flush = ($urandom % 100) < 5;
            s_dok   = (kq.size() > 0) && (($urandom % 100) < 40);
            s_rdata = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
